// File: rtl/neuron_pkg.sv
// Shared constants, FSM state type and accumulator bound helpers
// for the neuron ROM reader.
package neuron_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Two's-complement limits of a w-bit signed accumulator.
  function automatic logic signed [127:0] acc_max(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] acc_min(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/neuron_mac_sat.sv
// Combinational signed weight x sample product, sign-extended and added
// to the running sum, clamped at the accumulator's signed limits.
module neuron_mac_sat #(
  parameter int DATA_W = neuron_pkg::DATA_W,
  parameter int ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] weight_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [ACC_W-1:0]  sum_next_o,
  output logic              sat_o
);
  import neuron_pkg::*;

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      wide;

  assign prod = (2*DATA_W)'($signed(weight_i)) * (2*DATA_W)'($signed(sample_i));
  assign wide = $signed({acc_i[ACC_W-1], acc_i}) + (ACC_W+1)'(prod);

  // One guard bit: disagreeing top bits mean the add left the ACC_W range.
  always_comb begin
    sum_next_o = wide[ACC_W-1:0];
    sat_o      = 1'b0;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sat_o      = 1'b1;
      sum_next_o = wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/neuron_rom_reader.sv
// Walks a neuron's weight ROM, pairs each weight with one streamed input
// sample and reports the saturated perceptron sum plus a fire bit.
module neuron_rom_reader #(
  parameter int                      N_WEIGHTS = 10,
  parameter int                      ADDR_BASE = 1,
  parameter int                      DATA_W    = neuron_pkg::DATA_W,
  parameter int                      ACC_W     = 40,
  parameter logic signed [ACC_W-1:0] THRESHOLD = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic [neuron_pkg::ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]             rom_dout,
  input  logic                          x_valid,
  output logic                          x_ready,
  input  logic [DATA_W-1:0]             x_data,
  output logic                          y_valid,
  input  logic                          y_ready,
  output logic [ACC_W-1:0]              y_acc,
  output logic                          y_fire,
  output logic                          y_sat
);
  import neuron_pkg::*;

  localparam int               K_W    = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;
  localparam logic [K_W-1:0]   K_LAST = K_W'(N_WEIGHTS - 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(ADDR_BASE);

  state_e           state_q;
  logic [K_W-1:0]   k_q;
  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic             busy_q;
  logic             x_ready_q;
  logic             y_valid_q;
  logic [ACC_W-1:0] y_acc_q;
  logic             y_fire_q;
  logic             y_sat_q;

  logic [ACC_W-1:0] sum_next;
  logic             mac_sat;
  logic             accept;

  assign accept = (state_q == RUN) && x_valid;

  neuron_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .acc_i      (acc_q),
    .weight_i   (rom_dout),
    .sample_i   (x_data),
    .sum_next_o (sum_next),
    .sat_o      (mac_sat)
  );

  // Look one address ahead on accept so the ROM's registered read lines
  // up the next weight with the next sample, one weight per cycle.
  always_comb begin
    rom_addr = BASE;
    if (state_q == RUN) begin
      rom_addr = BASE + ADDR_W'(k_q) + ADDR_W'(accept);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_acc_q   <= '0;
      y_fire_q  <= 1'b0;
      y_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            k_q       <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b1;
            x_ready_q <= 1'b1;
            y_acc_q   <= '0;
            y_fire_q  <= 1'b0;
            y_sat_q   <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_q <= sum_next;
            sat_q <= sat_q | mac_sat;
            k_q   <= k_q + 1'b1;
            if (k_q == K_LAST) begin
              state_q   <= DONE;
              x_ready_q <= 1'b0;
              y_valid_q <= 1'b1;
              y_acc_q   <= sum_next;
              y_fire_q  <= $signed(sum_next) > THRESHOLD;
              y_sat_q   <= sat_q | mac_sat;
            end
          end
        end
        DONE: begin
          if (y_ready) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            y_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign x_ready = x_ready_q;
  assign y_valid = y_valid_q;
  assign y_acc   = y_acc_q;
  assign y_fire  = y_fire_q;
  assign y_sat   = y_sat_q;

endmodule

// File: tb/tb_neuron_rom_reader.sv
// Directed and randomized checks of neuron_rom_reader against a plain
// arithmetic model of the clamped weighted sum.
module tb_neuron_rom_reader;

  localparam int N    = 10;
  localparam int BASE = 1;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy;
  logic [15:0]        rom_addr;
  logic signed [15:0] rom_dout;
  logic               x_valid = 1'b0;
  logic               x_ready;
  logic [15:0]        x_data  = '0;
  logic               y_valid;
  logic               y_ready = 1'b0;
  logic signed [39:0] y_acc;
  logic               y_fire;
  logic               y_sat;

  logic               sStart  = 1'b0;
  logic               sBusy;
  logic [15:0]        sRomAddr;
  logic signed [15:0] sRomDout;
  logic               sXValid = 1'b0;
  logic               sXReady;
  logic [15:0]        sXData  = '0;
  logic               sYValid;
  logic               sYReady = 1'b0;
  logic signed [31:0] sYAcc;
  logic               sYFire;
  logic               sYSat;

  logic signed [15:0] romMem [0:63];
  int                 ws [N];
  int                 xs [N];
  int                 testCount = 0;
  int                 failCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= romMem[rom_addr[5:0]];
  always @(posedge clk) sRomDout <= 16'h8000;

  neuron_rom_reader #(
    .N_WEIGHTS (N),
    .ADDR_BASE (BASE),
    .DATA_W    (16),
    .ACC_W     (40),
    .THRESHOLD (40'sd20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_data   (x_data),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_acc    (y_acc),
    .y_fire   (y_fire),
    .y_sat    (y_sat)
  );

  neuron_rom_reader #(
    .N_WEIGHTS (N),
    .ADDR_BASE (BASE),
    .DATA_W    (16),
    .ACC_W     (32),
    .THRESHOLD (32'sd0)
  ) dutSat (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sStart),
    .busy     (sBusy),
    .rom_addr (sRomAddr),
    .rom_dout (sRomDout),
    .x_valid  (sXValid),
    .x_ready  (sXReady),
    .x_data   (sXData),
    .y_valid  (sYValid),
    .y_ready  (sYReady),
    .y_acc    (sYAcc),
    .y_fire   (sYFire),
    .y_sat    (sYSat)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Running sum clamped after every step to the accW-bit signed range.
  function automatic longint modelSum(input int accW, output bit satOut);
    longint acc;
    longint hi;
    longint lo;
    acc    = 0;
    hi     = (64'sd1 <<< (accW - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (accW - 1));
    satOut = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc += longint'(ws[i]) * longint'(xs[i]);
      if (acc > hi) begin
        acc    = hi;
        satOut = 1'b1;
      end else if (acc < lo) begin
        acc    = lo;
        satOut = 1'b1;
      end
    end
    return acc;
  endfunction

  function automatic void setDirected(input int xv);
    ws = '{0, 0, 4, 5, 6, 8, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) xs[i] = xv;
  endfunction

  task automatic applyStimulus(input string tag, input int maxGap, input int holdCycles);
    bit     expSat;
    longint expAcc;
    int     cyc;
    int     gap;
    int     totalGap;
    int     waitCnt;
    expAcc   = modelSum(40, expSat);
    totalGap = 0;
    for (int i = 0; i < N; i++) romMem[BASE + i] = 16'(ws[i]);

    @(negedge clk);
    start = 1'b1;
    cyc   = 0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    checkOutput({tag, " busy"}, 64'(busy), 64'sd1);

    for (int i = 0; i < N; i++) begin
      gap = int'($urandom_range(maxGap, 0));
      totalGap += gap;
      x_valid = 1'b0;
      repeat (gap) begin
        @(negedge clk);
        cyc++;
        checkOutput({tag, " gap addr"}, 64'(rom_addr), 64'(BASE + i));
        checkOutput({tag, " gap dout"}, 64'(rom_dout), 64'(ws[i]));
      end
      x_valid = 1'b1;
      x_data  = 16'(xs[i]);
      #1;
      checkOutput({tag, " weight"}, 64'(rom_dout), 64'(ws[i]));
      checkOutput({tag, " addr"}, 64'(rom_addr), 64'(BASE + i + 1));
      checkOutput({tag, " early yvalid"}, 64'(y_valid), 64'sd0);
      @(negedge clk);
      cyc++;
    end
    x_valid = 1'b0;

    waitCnt = 0;
    while (y_valid !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      cyc++;
      waitCnt++;
    end
    checkOutput({tag, " latency"}, 64'(cyc), 64'(N + 1 + totalGap));
    checkOutput({tag, " acc"}, 64'(y_acc), 64'(expAcc));
    checkOutput({tag, " fire"}, 64'(y_fire), 64'(expAcc > 20));
    checkOutput({tag, " sat"}, 64'(y_sat), 64'(expSat));
    checkOutput({tag, " xready"}, 64'(x_ready), 64'sd0);

    for (int h = 0; h < holdCycles; h++) begin
      start = (h == 1);
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, " hold valid"}, 64'(y_valid), 64'sd1);
      checkOutput({tag, " hold acc"}, 64'(y_acc), 64'(expAcc));
      checkOutput({tag, " hold xready"}, 64'(x_ready), 64'sd0);
    end

    // A start in the same cycle as the result handshake must be ignored.
    y_ready = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    start   = 1'b0;
    checkOutput({tag, " idle valid"}, 64'(y_valid), 64'sd0);
    checkOutput({tag, " idle busy"}, 64'(busy), 64'sd0);
    checkOutput({tag, " idle addr"}, 64'(rom_addr), 64'(BASE));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"}, 64'(busy), 64'sd0);
    checkOutput({tag, " xready"}, 64'(x_ready), 64'sd0);
    checkOutput({tag, " yvalid"}, 64'(y_valid), 64'sd0);
    checkOutput({tag, " yacc"}, 64'(y_acc), 64'sd0);
    checkOutput({tag, " yfire"}, 64'(y_fire), 64'sd0);
    checkOutput({tag, " ysat"}, 64'(y_sat), 64'sd0);
    checkOutput({tag, " addr"}, 64'(rom_addr), 64'(BASE));
  endtask

  initial begin
    bit     expSat;
    longint expAcc;
    int     waitCnt;

    for (int a = 0; a < 64; a++) romMem[a] = '0;

    @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    setDirected(1);
    applyStimulus("ones", 0, 0);
    setDirected(-1);
    applyStimulus("minus", 0, 0);
    setDirected(2);
    applyStimulus("stall", 3, 0);
    setDirected(1);
    applyStimulus("backpressure", 0, 5);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        ws[i] = int'($urandom_range(65535, 0)) - 32768;
        xs[i] = int'($urandom_range(65535, 0)) - 32768;
      end
      applyStimulus("random", 3, int'($urandom_range(4, 0)));
    end

    for (int i = 0; i < N; i++) begin
      ws[i] = -32768;
      xs[i] = -32768;
    end
    expAcc = modelSum(32, expSat);
    @(negedge clk);
    sStart = 1'b1;
    @(negedge clk);
    sStart  = 1'b0;
    sXValid = 1'b1;
    sXData  = 16'h8000;
    waitCnt = 0;
    while (sYValid !== 1'b1 && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    sXValid = 1'b0;
    checkOutput("satrun valid", 64'(sYValid), 64'sd1);
    checkOutput("satrun acc", 64'(sYAcc), 64'(expAcc));
    checkOutput("satrun sat", 64'(sYSat), 64'(expSat));
    checkOutput("satrun fire", 64'(sYFire), 64'(expAcc > 0));
    sYReady = 1'b1;
    @(negedge clk);
    sYReady = 1'b0;
    checkOutput("satrun idle", 64'(sBusy), 64'sd0);

    setDirected(1);
    for (int i = 0; i < N; i++) romMem[BASE + i] = 16'(ws[i]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      x_data  = 16'(xs[i]);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    x_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rerun", 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
